// File: rtl/cnt_pkg.sv
// Shared state encoding for the counter's next-state logic and its datapath stage.
// Both stages import this package so the 3-bit codes can never drift apart.
package cnt_pkg;

  localparam int unsigned CNT_WIDTH_DEFAULT = 8;

  // 3-bit state code as carried on next_state / state.
  typedef logic [2:0] cnt_state_t;

  localparam cnt_state_t CNT_IDLE = 3'b000;
  localparam cnt_state_t CNT_LOAD = 3'b001;
  localparam cnt_state_t CNT_INC  = 3'b010;
  localparam cnt_state_t CNT_INC2 = 3'b011;
  localparam cnt_state_t CNT_DEC  = 3'b100;
  localparam cnt_state_t CNT_DEC2 = 3'b101;

  // Count direction implied by a code: DEC/DEC2 share bit 2, INC/INC2 do not.
  function automatic logic cnt_is_down(input cnt_state_t code);
    return code[2];
  endfunction

endpackage

// File: rtl/cnt_addsub.sv
// Combinational WIDTH-bit add/subtract-by-one with carry/borrow out.
// Optional feature macro: CNT_SATURATE_EN (clamp at the range ends instead of wrapping).
module cnt_addsub
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             down_i,   // 1: subtract one, 0: add one
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o   // carry on add, borrow on subtract
);

  logic [WIDTH:0] ext_value;
  logic [WIDTH:0] one_ext;
  logic [WIDTH:0] sum;

  // Extended adder: bit WIDTH is the carry (add) or borrow (subtract) of the operation.
  always_comb begin
    ext_value = {1'b0, value_i};
    one_ext   = {{WIDTH{1'b0}}, 1'b1};
    sum       = down_i ? (ext_value - one_ext) : (ext_value + one_ext);
    carry_o   = sum[WIDTH];
`ifdef CNT_SATURATE_EN
    // Overflowing step clamps: up stays at all-ones, down stays at zero.
    if (sum[WIDTH]) begin
      result_o = down_i ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end else begin
      result_o = sum[WIDTH-1:0];
    end
`else
    result_o = sum[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/cnt_state_datapath.sv
// Counter datapath stage: registers the next-state code and applies the matching
// load/increment/decrement/hold action to the count register, with registered
// carry/borrow/illegal pulses. Optional feature macro: CNT_SATURATE_EN (in cnt_addsub).
module cnt_state_datapath
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       next_state,
  input  logic [WIDTH-1:0] d_in,
  output logic [2:0]       state,
  output logic [WIDTH-1:0] d_out,
  output logic             o_carry,
  output logic             o_borrow,
  output logic             o_illegal
);

  cnt_state_t       state_d, state_q;
  logic [WIDTH-1:0] count_d, count_q;
  logic             carry_d, carry_q;
  logic             borrow_d, borrow_q;
  logic             illegal_d, illegal_q;

  logic [WIDTH-1:0] step_result;
  logic             step_carry;
  logic             step_down;

  assign step_down = cnt_is_down(next_state);

  cnt_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .value_i  (count_q),
    .down_i   (step_down),
    .result_o (step_result),
    .carry_o  (step_carry)
  );

  // Decode the incoming code into next state, next count and flag pulses.
  always_comb begin
    state_d   = CNT_IDLE;
    count_d   = count_q;
    carry_d   = 1'b0;
    borrow_d  = 1'b0;
    illegal_d = 1'b0;
    case (next_state)
      CNT_IDLE: begin
        state_d = CNT_IDLE;
      end
      CNT_LOAD: begin
        state_d = CNT_LOAD;
        count_d = d_in;
      end
      CNT_INC, CNT_INC2: begin
        state_d = next_state;
        count_d = step_result;
        carry_d = step_carry;
      end
      CNT_DEC, CNT_DEC2: begin
        state_d  = next_state;
        count_d  = step_result;
        borrow_d = step_carry;
      end
      // 110, 111 and any X/Z code: fall back to IDLE and hold the count.
      default: begin
        state_d   = CNT_IDLE;
        illegal_d = 1'b1;
      end
    endcase
  end

  // State, count and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CNT_IDLE;
      count_q   <= '0;
      carry_q   <= 1'b0;
      borrow_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      carry_q   <= carry_d;
      borrow_q  <= borrow_d;
      illegal_q <= illegal_d;
    end
  end

  assign state     = state_q;
  assign d_out     = count_q;
  assign o_carry   = carry_q;
  assign o_borrow  = borrow_q;
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_cnt_state_datapath.sv
// Directed self-checking bench for cnt_state_datapath (WIDTH = 8).
module tb_cnt_state_datapath;

  logic       clk;
  logic       reset;
  logic [2:0] next_state;
  logic [7:0] d_in;
  logic [2:0] state;
  logic [7:0] d_out;
  logic       o_carry;
  logic       o_borrow;
  logic       o_illegal;

  int n_cmp;
  int n_bad;

  cnt_state_datapath #(
    .WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .next_state (next_state),
    .d_in       (d_in),
    .state      (state),
    .d_out      (d_out),
    .o_carry    (o_carry),
    .o_borrow   (o_borrow),
    .o_illegal  (o_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply the currently driven inputs at one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    next_state = 3'b001;
    d_in       = 8'hA5;
    step();
    step();
    n_cmp++;
    if (state !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_state: got %b want 000", state);
    end
    n_cmp++;
    if (d_out !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_dout: got %h want 00", d_out);
    end
    n_cmp++;
    if ({o_carry, o_borrow, o_illegal} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000", {o_carry, o_borrow, o_illegal});
    end
    reset = 1'b0;
  endtask

  task automatic test_load_inc();
    logic [2:0] ns_v [4] = '{3'b001, 3'b010, 3'b011, 3'b010};
    logic [7:0] exp_v [4] = '{8'h3C, 8'h3D, 8'h3E, 8'h3F};
    d_in = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      next_state = ns_v[i];
      step();
      n_cmp++;
      if (d_out !== exp_v[i] || state !== ns_v[i] || o_carry !== 1'b0) begin
        n_bad++;
        $display("FAIL load_inc[%0d]: got d_out=%h state=%b carry=%b want %h %b 0",
                 i, d_out, state, o_carry, exp_v[i], ns_v[i]);
      end
    end
  endtask

  task automatic test_inc_wrap();
    logic [7:0] exp_second;
`ifdef CNT_SATURATE_EN
    exp_second = 8'hFF;
`else
    exp_second = 8'h00;
`endif
    next_state = 3'b001;
    d_in       = 8'hFE;
    step();
    next_state = 3'b010;
    step();
    n_cmp++;
    if (d_out !== 8'hFF || o_carry !== 1'b0) begin
      n_bad++;
      $display("FAIL inc_wrap_1: got d_out=%h carry=%b want FF 0", d_out, o_carry);
    end
    next_state = 3'b011;
    step();
    n_cmp++;
    if (d_out !== exp_second || o_carry !== 1'b1 || o_borrow !== 1'b0) begin
      n_bad++;
      $display("FAIL inc_wrap_2: got d_out=%h carry=%b borrow=%b want %h 1 0",
               d_out, o_carry, o_borrow, exp_second);
    end
    next_state = 3'b000;
    step();
    n_cmp++;
    if (d_out !== exp_second || o_carry !== 1'b0 || state !== 3'b000) begin
      n_bad++;
      $display("FAIL inc_wrap_idle: got d_out=%h carry=%b state=%b want %h 0 000",
               d_out, o_carry, state, exp_second);
    end
  endtask

  task automatic test_dec_wrap();
    logic [7:0] exp_second;
`ifdef CNT_SATURATE_EN
    exp_second = 8'h00;
`else
    exp_second = 8'hFF;
`endif
    next_state = 3'b001;
    d_in       = 8'h01;
    step();
    next_state = 3'b100;
    step();
    n_cmp++;
    if (d_out !== 8'h00 || o_borrow !== 1'b0 || state !== 3'b100) begin
      n_bad++;
      $display("FAIL dec_wrap_1: got d_out=%h borrow=%b state=%b want 00 0 100",
               d_out, o_borrow, state);
    end
    next_state = 3'b101;
    step();
    n_cmp++;
    if (d_out !== exp_second || o_borrow !== 1'b1 || o_carry !== 1'b0) begin
      n_bad++;
      $display("FAIL dec_wrap_2: got d_out=%h borrow=%b carry=%b want %h 1 0",
               d_out, o_borrow, o_carry, exp_second);
    end
    next_state = 3'b000;
    step();
    n_cmp++;
    if (d_out !== exp_second || o_borrow !== 1'b0) begin
      n_bad++;
      $display("FAIL dec_wrap_idle: got d_out=%h borrow=%b want %h 0",
               d_out, o_borrow, exp_second);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] bad_v [3] = '{3'b110, 3'b111, 3'bxxx};
    logic       exp_ill;
    next_state = 3'b001;
    d_in       = 8'h55;
    step();
    for (int i = 0; i < 3; i++) begin
      next_state = bad_v[i];
      // A 2-state simulator may fold the X code onto a known value.
      exp_ill = $isunknown(next_state) || (next_state[2:1] == 2'b11);
      step();
      n_cmp++;
      if (state !== 3'b000 || d_out !== 8'h55) begin
        n_bad++;
        $display("FAIL illegal[%0d]: got state=%b d_out=%h want 000 55", i, state, d_out);
      end
      n_cmp++;
      if (o_illegal !== exp_ill) begin
        n_bad++;
        $display("FAIL illegal_pulse[%0d]: got %b want %b", i, o_illegal, exp_ill);
      end
      next_state = 3'b000;
      step();
      n_cmp++;
      if (o_illegal !== 1'b0 || d_out !== 8'h55) begin
        n_bad++;
        $display("FAIL illegal_clear[%0d]: got ill=%b d_out=%h want 0 55", i, o_illegal, d_out);
      end
    end
  endtask

  task automatic test_load_priority();
    logic [7:0] data_v [3] = '{8'hFF, 8'h00, 8'h80};
    next_state = 3'b001;
    for (int i = 0; i < 3; i++) begin
      d_in = data_v[i];
      step();
      n_cmp++;
      if (d_out !== data_v[i] || state !== 3'b001 || o_carry !== 1'b0 || o_borrow !== 1'b0) begin
        n_bad++;
        $display("FAIL load_prio[%0d]: got d_out=%h state=%b c=%b b=%b want %h 001 0 0",
                 i, d_out, state, o_carry, o_borrow, data_v[i]);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    next_state = 3'b001;
    d_in       = 8'h10;
    step();
    for (int i = 0; i < 3; i++) begin
      next_state = (i % 2 == 0) ? 3'b010 : 3'b011;
      step();
    end
    n_cmp++;
    if (d_out !== 8'h13) begin
      n_bad++;
      $display("FAIL mid_count_pre: got %h want 13", d_out);
    end
    reset      = 1'b1;
    next_state = 3'b011;
    step();
    n_cmp++;
    if (d_out !== 8'h00 || state !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_count_reset: got d_out=%h state=%b want 00 000", d_out, state);
    end
    reset      = 1'b0;
    next_state = 3'b010;
    step();
    n_cmp++;
    if (d_out !== 8'h01 || state !== 3'b010) begin
      n_bad++;
      $display("FAIL mid_count_resume: got d_out=%h state=%b want 01 010", d_out, state);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    next_state = 3'b000;
    d_in       = 8'h00;
    test_reset();
    test_load_inc();
    test_inc_wrap();
    test_dec_wrap();
    test_illegal();
    test_load_priority();
    test_reset_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
